fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the RV32I 5-stage pipeline; sits directly upstream of decode.
- Holds PC_F and issues word requests to instruction memory over a valid/ready request channel with a variable-latency response.
- Delivers instr/PC/PC+4 into the D stage, honouring stallF/stallD from the hazard unit and PCSrc_E/PCTarget_E redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) written into D on flush or empty slot.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active low.
- stallF  input  1  when 1, no new imem request is issued.
- stallD  input  1  when 1, IF/ID register holds its contents.
- PCSrc_E  input  1  redirect strobe from execute (taken branch/jump); also flushes D.
- PCTarget_E  input  32  redirect target, sampled when PCSrc_E=1.
- imem_req_valid  output  1  request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  32  request byte address (= PC_F).
- imem_rsp_valid  input  1  response data valid.
- imem_rsp_data  input  32  fetched instruction.
- instr_D  output  32  IF/ID instruction.
- PC_D  output  32  IF/ID PC.
- PCPlus4_D  output  32  IF/ID PC+4.
- valid_D  output  1  1 = D holds a real instruction, 0 = bubble.

Behaviour:
- Reset (rst_n=0 at edge): PC_F=RESET_PC, state=S_REQ, kill=0, hold buffer empty, instr_D=NOP_INSTR, PC_D=0, PCPlus4_D=0, valid_D=0. imem_req_valid is forced to 0 while rst_n=0.
- At most one outstanding request.
- imem_addr = PC_F at all times.
- All PC arithmetic is modulo 2^32.
- D-stage update rule, evaluated every cycle in priority order:
  1. PCSrc_E=1: D loaded with NOP_INSTR, valid_D=0. Overrides stallD.
  2. stallD=1: D holds.
  3. An instruction is delivered this cycle: D loads {instr, PC, PC+4}, valid_D=1.
  4. Otherwise: D loads NOP_INSTR with valid_D=0. PC_D and PCPlus4_D are don't-care for verification.
- States:
  - S_REQ: imem_req_valid = ~stallF. Handshake (valid&ready) moves to S_WAIT. imem_addr stays stable while valid is held and ready=0. If stallF rises before the handshake, valid drops; no handshake occurs.
  - S_WAIT: waiting for imem_rsp_valid.
    - kill=1: response discarded, kill cleared, go to S_REQ.
    - kill=0 and deliverable (PCSrc_E=0, stallD=0): deliver to D; PC_F<=PC_F+4; go to S_REQ.
    - kill=0 and stallD=1: capture {data, PC_F} in hold buffer; go to S_HOLD.
  - S_HOLD: when stallD=0 and PCSrc_E=0, deliver the buffered instruction; PC_F<=PC_F+4; go to S_REQ.
- Redirect (PCSrc_E=1), any state: PC_F<=PCTarget_E, and PC_F+4 is not applied that cycle.
  - S_WAIT with no response this cycle: kill<=1.
  - S_REQ with handshake this cycle: go to S_WAIT with kill<=1; the request for the old PC gets squashed.
  - S_WAIT with response this cycle: response discarded, go to S_REQ.
  - S_HOLD: buffer dropped, go to S_REQ.
- imem_rsp_valid outside S_WAIT is ignored, e.g. a stale response after reset.
- Throughput: one instruction per 2 cycles minimum (request cycle + response cycle). Response is legal no earlier than the cycle after the handshake.
- Each fetched, non-killed instruction enters D exactly once: no duplication, no loss.

Test Plan:
- Reset release, ready=1, memory responds 1 cycle after accept with data=addr|0x13 → imem_addr 0x0,0x4,0x8; D sees PC_D 0x0,0x4,0x8 with valid_D=1, NOP bubbles (valid_D=0) in between.
- stallD=1 for 3 cycles covering the response of PC 0x8 → S_HOLD, D frozen at PC 0x4. After release, PC_D=0x8 exactly once, next imem_addr=0xC.
- PCSrc_E=1, PCTarget_E=0x100 while waiting on PC 0xC, response arrives 2 cycles later → response discarded, next imem_addr=0x100, D gets NOP/valid_D=0, then PC_D=0x100.
- PCSrc_E=1 and stallD=1 in the same cycle → D becomes NOP_INSTR, valid_D=0 (flush wins). PC_F=target.
- imem_req_ready=0 for 5 cycles at PC 0x20 → imem_req_valid=1 and imem_addr=0x20 stable all 5 cycles, exactly one handshake. stallF=1 in S_REQ → imem_req_valid=0.
- rst_n=0 for one cycle while in S_WAIT, then a stray imem_rsp_valid arrives → ignored; imem_addr=RESET_PC, valid_D=0, normal fetch resumes from RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with variable-latency imem and IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        PCSrc_E,
    input  logic [31:0] PCTarget_E,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PCPlus4_D,
    output logic        valid_D
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
    state_t state, state_nx;
    logic [31:0] pc_f, pc_nx, hold_instr, hold_instr_nx, hold_pc, hold_pc_nx, del_instr, del_pc;
    logic kill, kill_nx, hs, deliver;
    assign imem_addr = pc_f;
    always_comb begin
        imem_req_valid = rst_n && state == S_REQ && !stallF;
        hs = imem_req_valid && imem_req_ready;
        deliver = !PCSrc_E && !stallD && ((state == S_WAIT && imem_rsp_valid && !kill) || state == S_HOLD);
        del_instr = state == S_HOLD ? hold_instr : imem_rsp_data;
        del_pc = state == S_HOLD ? hold_pc : pc_f;
        pc_nx = PCSrc_E ? PCTarget_E : deliver ? pc_f + 32'd4 : pc_f;
        state_nx = state;
        kill_nx = kill;
        hold_instr_nx = hold_instr;
        hold_pc_nx = hold_pc;
        case (state)
            S_REQ: if (hs) begin
                state_nx = S_WAIT;
                kill_nx = PCSrc_E;
            end
            S_WAIT: if (imem_rsp_valid) begin
                kill_nx = 1'b0;
                state_nx = (!kill && !PCSrc_E && stallD) ? S_HOLD : S_REQ;
                hold_instr_nx = imem_rsp_data;
                hold_pc_nx = pc_f;
            end else if (PCSrc_E) begin
                kill_nx = 1'b1;
            end
            S_HOLD: if (PCSrc_E || !stallD) state_nx = S_REQ;
            default: state_nx = S_REQ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_REQ;
            pc_f <= RESET_PC;
            kill <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc <= 32'h0;
            instr_D <= NOP_INSTR;
            PC_D <= 32'h0;
            PCPlus4_D <= 32'h0;
            valid_D <= 1'b0;
        end else begin
            state <= state_nx;
            pc_f <= pc_nx;
            kill <= kill_nx;
            hold_instr <= hold_instr_nx;
            hold_pc <= hold_pc_nx;
            if (PCSrc_E) begin
                instr_D <= NOP_INSTR;
                valid_D <= 1'b0;
            end else if (!stallD) begin
                instr_D <= deliver ? del_instr : NOP_INSTR;
                valid_D <= deliver;
                if (deliver) begin
                    PC_D <= del_pc;
                    PCPlus4_D <= del_pc + 32'd4;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 0, rst_n = 0, stallF = 0, stallD = 0, PCSrc_E = 0, imem_req_ready = 1, imem_rsp_valid = 0;
    logic [31:0] PCTarget_E = 0, imem_rsp_data = 0;
    logic imem_req_valid, valid_D;
    logic [31:0] imem_addr, instr_D, PC_D, PCPlus4_D;
    int pass_cnt = 0, total = 0, nhs = 0, lat = 1, cnt = 0, base = 0;
    bit pend = 0, stray = 0, hs = 0;
    logic [31:0] paddr = 0, hs_addr = 0, a;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD),
        .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_D(instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D), .valid_D(valid_D)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else pass_cnt++;
    endtask

    // one clock of memory model + DUT; memory answers lat cycles after accept with addr|0x13
    task automatic cyc();
        imem_rsp_valid = stray || (pend && cnt == 0);
        imem_rsp_data = stray ? 32'hdead_0013 : (paddr | 32'h13);
        #1;
        hs = imem_req_valid && imem_req_ready;
        hs_addr = imem_addr;
        if (hs) nhs++;
        @(posedge clk);
        #1;
        if (imem_rsp_valid) pend = 0;
        if (hs) begin
            pend = 1;
            cnt = lat - 1;
            paddr = hs_addr;
        end else if (pend && cnt > 0) begin
            cnt--;
        end
        imem_rsp_valid = 0;
    endtask

    initial begin
        cyc();
        cyc();
        #1;
        check("rst_req_v", {31'b0, imem_req_valid}, 0);
        check("rst_valid_d", {31'b0, valid_D}, 0);
        check("rst_instr_d", instr_D, NOP);
        check("rst_pc_d", PC_D, 0);
        check("rst_pc4_d", PCPlus4_D, 0);
        check("rst_addr", imem_addr, 0);
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            a = 32'(4 * i);
            #1;
            check("seq_req_v", {31'b0, imem_req_valid}, 1);
            check("seq_addr", imem_addr, a);
            cyc();
            check("seq_bubble", {31'b0, valid_D}, 0);
            cyc();
            check("seq_valid_d", {31'b0, valid_D}, 1);
            check("seq_pc_d", PC_D, a);
            check("seq_instr_d", instr_D, a | 32'h13);
            check("seq_pc4_d", PCPlus4_D, a + 4);
        end
        stallD = 1;
        #1;
        check("stall_addr", imem_addr, 32'h8);
        repeat (3) begin
            cyc();
            check("frz_valid", {31'b0, valid_D}, 1);
            check("frz_pc", PC_D, 32'h4);
        end
        check("hold_noreq", {31'b0, imem_req_valid}, 0);
        stallD = 0;
        cyc();
        check("hold_valid", {31'b0, valid_D}, 1);
        check("hold_pc", PC_D, 32'h8);
        check("hold_instr", instr_D, 32'h1b);
        check("hold_next_addr", imem_addr, 32'hc);
        lat = 3;
        cyc();
        check("once_bubble", {31'b0, valid_D}, 0);
        PCSrc_E = 1;
        PCTarget_E = 32'h100;
        cyc();
        PCSrc_E = 0;
        check("redir_flush", {31'b0, valid_D}, 0);
        check("redir_addr", imem_addr, 32'h100);
        #1;
        check("kill_noreq", {31'b0, imem_req_valid}, 0);
        cyc();
        check("kill_wait_d", {31'b0, valid_D}, 0);
        cyc();
        check("kill_discard", {31'b0, valid_D}, 0);
        #1;
        check("kill_req_v", {31'b0, imem_req_valid}, 1);
        check("kill_req_addr", imem_addr, 32'h100);
        lat = 1;
        cyc();
        check("tgt_bubble", {31'b0, valid_D}, 0);
        cyc();
        check("tgt_valid", {31'b0, valid_D}, 1);
        check("tgt_pc", PC_D, 32'h100);
        check("tgt_instr", instr_D, 32'h113);
        PCSrc_E = 1;
        stallD = 1;
        PCTarget_E = 32'h20;
        cyc();
        PCSrc_E = 0;
        stallD = 0;
        check("flushwin_valid", {31'b0, valid_D}, 0);
        check("flushwin_instr", instr_D, NOP);
        check("flushwin_addr", imem_addr, 32'h20);
        cyc();
        check("squash_valid", {31'b0, valid_D}, 0);
        #1;
        check("squash_req_v", {31'b0, imem_req_valid}, 1);
        check("squash_addr", imem_addr, 32'h20);
        imem_req_ready = 0;
        base = nhs;
        repeat (5) begin
            #1;
            check("bp_req_v", {31'b0, imem_req_valid}, 1);
            check("bp_addr", imem_addr, 32'h20);
            cyc();
        end
        check("bp_no_hs", 32'(nhs - base), 0);
        imem_req_ready = 1;
        cyc();
        check("bp_one_hs", 32'(nhs - base), 1);
        cyc();
        check("bp_valid", {31'b0, valid_D}, 1);
        check("bp_pc", PC_D, 32'h20);
        check("bp_instr", instr_D, 32'h33);
        stallF = 1;
        #1;
        check("stallf_req_v", {31'b0, imem_req_valid}, 0);
        cyc();
        check("stallf_addr", imem_addr, 32'h24);
        stallF = 0;
        #1;
        check("unstallf_req_v", {31'b0, imem_req_valid}, 1);
        cyc();
        pend = 0;
        rst_n = 0;
        #1;
        check("rst2_req_v", {31'b0, imem_req_valid}, 0);
        cyc();
        rst_n = 1;
        check("rst2_addr", imem_addr, 32'h0);
        check("rst2_valid", {31'b0, valid_D}, 0);
        check("rst2_instr", instr_D, NOP);
        stray = 1;
        cyc();
        stray = 0;
        check("stray_ignored", {31'b0, valid_D}, 0);
        cyc();
        check("resume_valid", {31'b0, valid_D}, 1);
        check("resume_pc", PC_D, 32'h0);
        check("resume_instr", instr_D, 32'h13);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
